dmem_arbiter: RTL

Sequential arbiter that shares the single-port 16-bit data memory between the CPU load/store path and an external loader/debug port. It sits between the datapath's ALU-result/R2 outputs and the data memory. It stalls the CPU (PC hold) while a CPU access is pending, and returns read data with a done pulse. It uses round-robin arbitration, with a bounded lock so a loader burst cannot starve the CPU.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_lock_ctr.sv | 40 ++++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, owner
// constants and default widths.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_AW       = 16;
  localparam int DEF_DW       = 16;
  localparam int DEF_MAX_LOCK = 8;

  // Lock counter width; holds MAX_LOCK values up to 255.
  localparam int LOCK_CW = 8;

  typedef enum logic [1:0] {
    ARB  = 2'd0,   // choose an owner, no strobes
    XFER = 2'd1,   // strobes driven for the latched owner
    RESP = 2'd2    // read data captured and returned
  } arbState_e;

  typedef logic owner_t;
  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_EXT = 1'b1;

endpackage

// File: rtl/dmem_arb_lock_ctr.sv
// -----------------------------------------------------------------------------
// dmem_arb_lock_ctr
// Saturating count of consecutive locked EXT grants made while the CPU waits.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   clr          clear the count (wins over inc)
//   inc          increment, saturating at MAX_LOCK
//   expired      count has reached MAX_LOCK
// -----------------------------------------------------------------------------
module dmem_arb_lock_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [LOCK_CW-1:0] LOCK_MAX = LOCK_CW'(MAX_LOCK);

  logic [LOCK_CW-1:0] lockCnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lockCnt <= '0;
    end else if (clr) begin
      lockCnt <= '0;
    end else if (inc && (lockCnt != LOCK_MAX)) begin
      lockCnt <= lockCnt + LOCK_CW'(1);
    end
  end

  assign expired = (lockCnt == LOCK_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store path and an
// external loader/debug port. Round-robin between the two, with a bounded
// EXT burst lock so a loader cannot starve the CPU.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request, held until cpu_done
//   cpu_rdata, cpu_done, cpu_stall  CPU response; stall = req & ~done
//   ext_req/we/addr/wdata, ext_lock external request and burst lock
//   ext_rdata, ext_done             external response
//   mem_re, mem_we, mem_addr,
//   mem_wdata, mem_rdata            memory side; rdata valid cycle after re
// Timing (grant at edge T):
//   write: strobe and done visible in cycle T+1 (XFER)
//   read : mem_re in T+1, data captured at the end of RESP (edge T+2) and
//          presented with done in the cycle after RESP.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  input  logic          ext_lock,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_done,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arbState_e     state, nextState;
  owner_t        owner, lastGnt, grantOwner;
  logic          ownWe, doGrant;
  logic          cpuActive, extActive;
  logic          lockExpired, lockInc, lockClr;
  logic          grantWe;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantWdata;

  assign cpu_stall = cpu_req & ~cpu_done;

  // A requester whose done is showing this cycle has not yet had a chance to
  // drop or change its request, so it only counts again one cycle later.
  assign cpuActive = cpu_req & ~cpu_done;
  assign extActive = ext_req & ~ext_done;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    nextState  = state;
    doGrant    = 1'b0;
    grantOwner = OWN_CPU;
    unique case (state)
      ARB: begin
        if (cpuActive && extActive) begin
          doGrant = 1'b1;
          if ((lastGnt == OWN_EXT) && ext_lock && !lockExpired) begin
            grantOwner = OWN_EXT;
          end else begin
            grantOwner = (lastGnt == OWN_EXT) ? OWN_CPU : OWN_EXT;
          end
        end else if (cpuActive) begin
          doGrant    = 1'b1;
          grantOwner = OWN_CPU;
        end else if (extActive) begin
          doGrant    = 1'b1;
          grantOwner = OWN_EXT;
        end
        if (doGrant) nextState = XFER;
      end
      XFER:    nextState = ownWe ? ARB : RESP;
      RESP:    nextState = ARB;
      default: nextState = ARB;
    endcase
  end

  assign grantWe    = (grantOwner == OWN_EXT) ? ext_we    : cpu_we;
  assign grantAddr  = (grantOwner == OWN_EXT) ? ext_addr  : cpu_addr;
  assign grantWdata = (grantOwner == OWN_EXT) ? ext_wdata : cpu_wdata;

  // Only locked EXT grants that actually hold the CPU off count toward the bound.
  assign lockInc = doGrant && (grantOwner == OWN_EXT) && cpu_req && ext_lock;
  assign lockClr = doGrant && ((grantOwner == OWN_CPU) || !ext_lock);

  dmem_arb_lock_ctr #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (lockClr),
    .inc     (lockInc),
    .expired (lockExpired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB;
      lastGnt   <= OWN_EXT;
      owner     <= OWN_CPU;
      ownWe     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      ext_done  <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      state    <= nextState;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      cpu_done <= 1'b0;
      ext_done <= 1'b0;
      unique case (state)
        ARB: begin
          if (doGrant) begin
            // mem_addr/mem_wdata double as the latched request fields.
            owner     <= grantOwner;
            lastGnt   <= grantOwner;
            ownWe     <= grantWe;
            mem_addr  <= grantAddr;
            mem_wdata <= grantWdata;
            mem_we    <= grantWe;
            mem_re    <= ~grantWe;
            // A write completes in XFER, so its done rides with the strobe.
            cpu_done  <= grantWe && (grantOwner == OWN_CPU);
            ext_done  <= grantWe && (grantOwner == OWN_EXT);
          end
        end
        RESP: begin
          if (owner == OWN_CPU) begin
            cpu_rdata <= mem_rdata;
            cpu_done  <= 1'b1;
          end else begin
            ext_rdata <= mem_rdata;
            ext_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
